dpram_fifo_ctrl: RTL and testbench

//   Sequences the 16x8 dual-port RAM (dpram) as a synchronous FIFO.

---
 rtl/dpram_fifo_ctrl.sv | 95 +++++++++
 tb/tb_dpram_fifo_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller for a 16x8 dual-port RAM: turns push/pop requests into
// RAM strobes and addresses, and tracks wrapping pointers, occupancy and status flags.
module dpram_fifo_ctrl #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int AF_LEVEL = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr_wr,
    output logic [AW-1:0] ram_addr_rd,
    output logic [DW-1:0] ram_data_in,
    input  logic [DW-1:0] ram_data_out
);

    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_THRESH = AF_LEVEL[AW:0];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    // Flags come from registered pointers only, so acceptance never loops back on itself.
    // Pointers carry an extra wrap bit to tell full from empty when the low bits match.
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign almost_full = (count >= AF_THRESH);

    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    assign ram_we      = push_ok;
    assign ram_re      = pop_ok;
    assign ram_addr_wr = wr_ptr[AW-1:0];
    assign ram_addr_rd = rd_ptr[AW-1:0];
    assign ram_data_in = push_data;
    assign pop_data    = ram_data_out;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
        end
    end

    // pop_valid mirrors the RAM's one-cycle read latency; an in-flight beat survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pop_valid <= 1'b0;
        else        pop_valid <= pop_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) overflow  <= 1'b1;
            if (pop && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: directed scenarios plus randomized traffic,
// compared against a queue-based FIFO model driving a behavioural dual-port RAM.
module tb_dpram_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr_wr;
    logic [AW-1:0] ram_addr_rd;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.AW(AW), .DW(DW), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_valid   (pop_valid),
        .pop_data    (pop_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_addr_wr (ram_addr_wr),
        .ram_addr_rd (ram_addr_rd),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    // Behavioural dual-port RAM with a registered read port.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr_wr] <= ram_data_in;
        if (ram_re) ram_data_out <= mem[ram_addr_rd];
    end

    // Reference model: contents as a queue, addresses as running totals of accepted ops.
    logic [DW-1:0] q[$];
    int            wtot;
    int            rtot;
    bit            m_ovf;
    bit            m_unf;
    bit            m_pv;
    logic [DW-1:0] m_pd;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wtot  = 0;
        rtot  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_pv  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"},     32'(count),       32'(q.size()));
        check({tag, ".full"},      32'(full),        32'(q.size() == DEPTH));
        check({tag, ".empty"},     32'(empty),       32'(q.size() == 0));
        check({tag, ".af"},        32'(almost_full), 32'(q.size() >= AF));
        check({tag, ".overflow"},  32'(overflow),    32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow),   32'(m_unf));
        check({tag, ".pop_valid"}, 32'(pop_valid),   32'(m_pv));
        if (m_pv) check({tag, ".pop_data"}, 32'(pop_data), 32'(m_pd));
    endtask

    // One clock of traffic; entered and left 1 time unit after a rising edge.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit o, input bit f,
                        input string tag);
        bit m_full, m_empty, wok, rok;
        push      = p;
        push_data = d;
        pop       = o;
        flush     = f;
        m_full    = (q.size() == DEPTH);
        m_empty   = (q.size() == 0);
        wok       = p && !m_full && !f;
        rok       = o && !m_empty && !f;
        #1;
        check({tag, ".ram_we"},      32'(ram_we),      32'(wok));
        check({tag, ".ram_re"},      32'(ram_re),      32'(rok));
        check({tag, ".addr_wr"},     32'(ram_addr_wr), 32'(wtot % DEPTH));
        check({tag, ".addr_rd"},     32'(ram_addr_rd), 32'(rtot % DEPTH));
        check({tag, ".data_in"},     32'(ram_data_in), 32'(d));
        check({tag, ".pv_pre"},      32'(pop_valid),   32'(m_pv));
        @(posedge clk);
        if (f) begin
            q.delete();
            wtot  = 0;
            rtot  = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (rok) begin
                m_pd = q.pop_front();
                rtot++;
            end
            if (wok) begin
                q.push_back(d);
                wtot++;
            end
            if (p && m_full)  m_ovf = 1'b1;
            if (o && m_empty) m_unf = 1'b1;
        end
        m_pv = rok;
        #1;
        check_status(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        rst_n = 1'b1;

        // Fill with 0x00..0x0F; almost_full from 12, full after the 16th edge.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
        check("fill.full_final", 32'(full), 32'h1);

        // Push while full is rejected and sets overflow.
        step(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");

        // Drain: data must come back 0x00..0x0F, one per clock.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
            check("drain.order", 32'(pop_data), 32'(i));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, "idle");

        // Pop while empty, then push+pop while empty: push wins, underflow set.
        step(1'b0, 8'h00, 1'b1, 1'b0, "unf");
        step(1'b1, 8'h31, 1'b1, 1'b0, "unf_pp");

        // Build to three entries and stream push+pop for 40 clocks across pointer wrap.
        step(1'b1, 8'h32, 1'b0, 1'b0, "pre3");
        step(1'b1, 8'h33, 1'b0, 1'b0, "pre3");
        for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, "stream");

        // Flush with push high and a pop beat in flight.
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "pre_flush");
        step(1'b0, 8'h00, 1'b1, 1'b0, "pre_flush_pop");
        step(1'b1, 8'h77, 1'b0, 1'b1, "flush");
        step(1'b0, 8'h00, 1'b0, 1'b0, "post_flush");

        // Async reset with a pop issued the clock before.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "pre_rst");
        step(1'b0, 8'h00, 1'b1, 1'b0, "pre_rst_pop");
        push  = 1'b0;
        pop   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_status("rst_mid");
        @(posedge clk);
        #1;
        check_status("rst_hold");
        rst_n = 1'b1;
        step(1'b1, 8'h55, 1'b0, 1'b0, "rst_push");
        step(1'b0, 8'h00, 1'b1, 1'b0, "rst_pop");
        check("rst_pop.data55", 32'(pop_data), 32'h55);

        // Randomized traffic: push-heavy then pop-heavy to visit full and empty.
        for (int i = 0; i < 400; i++) begin
            bit p, o, f;
            p = (i < 200) ? ($urandom_range(99) < 75) : ($urandom_range(99) < 30);
            o = (i < 200) ? ($urandom_range(99) < 30) : ($urandom_range(99) < 75);
            f = ($urandom_range(99) < 2);
            step(p, 8'($urandom), o, f, "rand");
        end

        // Push+pop while full: pop accepted, push rejected.
        while (q.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, 1'b0, "refill");
        step(1'b1, 8'hEE, 1'b1, 1'b0, "full_pp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
